// File: rtl/aes_pkg.sv
// Shared AES definitions for the decrypt core and its mode controller.
// Holds key-size codes, fixed datapath widths, the controller's FSM state
// type and the round-count lookup.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned KEY_W   = 256;

  typedef enum logic [1:0] {
    AES_128 = 2'b00,
    AES_192 = 2'b01,
    AES_256 = 2'b10
  } key_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_OUT
  } ctrl_state_e;

  // Number of rounds for a key-size code; the unused code 2'b11 maps to AES-128.
  function automatic int unsigned nr_of(input logic [1:0] mode);
    case (mode)
      AES_192: nr_of = 12;
      AES_256: nr_of = 14;
      default: nr_of = 10;
    endcase
  endfunction

endpackage

// File: rtl/aes_dec_mode_ctrl_if.sv
// Stream-side bundle of the AES decrypt mode controller.
//   cfg_*  : configuration handshake (key size, CBC enable, key, IV)
//   in_*   : ciphertext valid/ready stream with last-block marker
//   out_*  : plaintext valid/ready stream with last-block marker
// master : system fabric side (drives config and ciphertext, accepts plaintext)
// slave  : controller side
interface aes_dec_mode_ctrl_if;
  import aes_pkg::*;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_mode;
  logic               cfg_cbc;
  logic [KEY_W-1:0]   cfg_key;
  logic [BLOCK_W-1:0] cfg_iv;

  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic               in_last;

  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               out_last;

  modport master (
    output cfg_valid, cfg_mode, cfg_cbc, cfg_key, cfg_iv,
    input  cfg_ready,
    output in_valid, in_data, in_last,
    input  in_ready,
    input  out_valid, out_data, out_last,
    output out_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_cbc, cfg_key, cfg_iv,
    output cfg_ready,
    input  in_valid, in_data, in_last,
    output in_ready,
    output out_valid, out_data, out_last,
    input  out_ready
  );

endinterface

// File: rtl/aes_cbc_chain.sv
// CBC chaining state: IV register, chaining register and the output XOR.
//   load    : capture a new IV; chaining restarts from it
//   update  : chaining register takes the ciphertext just decrypted
//   restart : chaining register returns to the stored IV (end of message)
//   cbc     : 1 applies the chaining XOR, 0 passes core output through (ECB)
//   result  : pt_in ^ chain (CBC) or pt_in (ECB), combinational
module aes_cbc_chain
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [BLOCK_W-1:0] iv_in,
  input  logic               update,
  input  logic [BLOCK_W-1:0] ct_in,
  input  logic               restart,
  input  logic               cbc,
  input  logic [BLOCK_W-1:0] pt_in,
  output logic [BLOCK_W-1:0] result
);

  logic [BLOCK_W-1:0] iv_r;
  logic [BLOCK_W-1:0] chain_r;

  // Strobes come from distinct FSM states, so at most one is active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iv_r    <= '0;
      chain_r <= '0;
    end else if (load) begin
      iv_r    <= iv_in;
      chain_r <= iv_in;
    end else if (update) begin
      chain_r <= ct_in;
    end else if (restart) begin
      chain_r <= iv_r;
    end
  end

  assign result = pt_in ^ (cbc ? chain_r : '0);

endmodule

// File: rtl/aes_dec_mode_ctrl.sv
// Sequencing controller for the iterative AES decrypt core.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : config handshake, ciphertext in-stream, plaintext out-stream
//   busy            : high whenever the FSM is not idle
//   core_rst        : active-high reset for the core (= !rst_n)
//   core_start      : one-cycle start pulse per block
//   core_mode/key/ciphertext : registered core inputs, stable for a whole block
//   core_plaintext, core_done : core result; done is only honoured in WAIT
module aes_dec_mode_ctrl
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  aes_dec_mode_ctrl_if.slave bus,
  output logic               busy,
  output logic               core_rst,
  output logic               core_start,
  output logic [1:0]         core_mode,
  output logic [KEY_W-1:0]   core_key,
  output logic [BLOCK_W-1:0] core_ciphertext,
  input  logic [BLOCK_W-1:0] core_plaintext,
  input  logic               core_done
);

  ctrl_state_e state, state_next;

  logic [1:0]         mode_r;
  logic               cbc_r;
  logic [KEY_W-1:0]   key_r;
  logic [BLOCK_W-1:0] ct_r;
  logic               last_r;
  logic [BLOCK_W-1:0] out_r;
  logic               cfg_ok;

  logic               cfg_load;
  logic               in_take;
  logic               chain_update;
  logic               chain_restart;
  logic               out_load;
  logic               cfg_ready_c;
  logic               in_ready_c;
  logic               out_valid_c;
  logic [BLOCK_W-1:0] chain_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_r <= '0;
      cbc_r  <= 1'b0;
      key_r  <= '0;
      ct_r   <= '0;
      last_r <= 1'b0;
      out_r  <= '0;
      cfg_ok <= 1'b0;
    end else begin
      state <= state_next;
      if (cfg_load) begin
        mode_r <= (bus.cfg_mode == 2'b11) ? AES_128 : bus.cfg_mode;
        cbc_r  <= bus.cfg_cbc;
        key_r  <= bus.cfg_key;
        cfg_ok <= 1'b1;
      end
      if (in_take) begin
        ct_r   <= bus.in_data;
        last_r <= bus.in_last;
      end
      if (out_load) out_r <= chain_result;
    end
  end

  always_comb begin
    state_next    = state;
    cfg_ready_c   = 1'b0;
    in_ready_c    = 1'b0;
    out_valid_c   = 1'b0;
    core_start    = 1'b0;
    cfg_load      = 1'b0;
    in_take       = 1'b0;
    chain_update  = 1'b0;
    chain_restart = 1'b0;
    out_load      = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready_c = 1'b1;
        // Config wins over data in the same cycle; in_ready drops so the
        // source keeps its block for the next cycle.
        if (bus.cfg_valid) begin
          cfg_load = 1'b1;
        end else begin
          in_ready_c = cfg_ok;
          if (bus.in_valid && cfg_ok) begin
            in_take    = 1'b1;
            state_next = ST_START;
          end
        end
      end
      ST_START: begin
        core_start = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          out_load     = 1'b1;
          chain_update = 1'b1;
          state_next   = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          chain_restart = last_r;
          state_next    = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  aes_cbc_chain u_chain (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cfg_load),
    .iv_in   (bus.cfg_iv),
    .update  (chain_update),
    .ct_in   (ct_r),
    .restart (chain_restart),
    .cbc     (cbc_r),
    .pt_in   (core_plaintext),
    .result  (chain_result)
  );

  assign bus.cfg_ready   = cfg_ready_c;
  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_data    = out_r;
  assign bus.out_last    = last_r;
  assign busy            = (state != ST_IDLE);
  assign core_rst        = !rst_n;
  assign core_mode       = mode_r;
  assign core_key        = key_r;
  assign core_ciphertext = ct_r;

endmodule
